// File: rtl/signed_shift_pkg.sv
// Shared types for the sequential signed power-of-two divider.
package signed_shift_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_ASR = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

endpackage

// File: rtl/arithmetic_shift_step.sv
// One-bit arithmetic right shift that folds the shifted-out bit into a sticky flag.
module arithmetic_shift_step #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] data,
    input  logic         sticky,
    output logic [N-1:0] shifted,
    output logic         sticky_out
);

    assign shifted    = {data[N-1], data[N-1:1]};
    assign sticky_out = sticky | data[0];

endmodule

// File: rtl/seq_signed_pow2_divider.sv
// Bit-serial arithmetic right shift by a runtime amount, with optional
// truncate-toward-zero correction so the result equals signed division by 2^S.
module seq_signed_pow2_divider
    import signed_shift_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned SW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shift,
    input  logic          up_mode,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [N-1:0]  down_data,
    output logic          busy
);

    state_t        state, state_nx;
    mode_t         mode, mode_nx;
    logic [N-1:0]  work, work_nx;
    logic [SW-1:0] count, count_nx;
    logic          sticky, sticky_nx;
    logic [N-1:0]  result_nx;
    logic          load_result;
    logic [SW-1:0] shift_clamped;
    logic [N-1:0]  step_data;
    logic          step_sticky;

    assign shift_clamped = (up_shift > SW'(N)) ? SW'(N) : up_shift;

    arithmetic_shift_step #(.N(N)) u_step (
        .data       (work),
        .sticky     (sticky),
        .shifted    (step_data),
        .sticky_out (step_sticky)
    );

    // Next-state and datapath decode
    always_comb begin
        state_nx  = state;
        mode_nx   = mode;
        work_nx   = work;
        count_nx  = count;
        sticky_nx = sticky;
        case (state)
            IDLE: begin
                if (up_valid) begin
                    work_nx   = up_data;
                    count_nx  = shift_clamped;
                    mode_nx   = mode_t'(up_mode);
                    sticky_nx = 1'b0;
                    state_nx  = (shift_clamped == SW'(0)) ? DONE : BUSY;
                end
            end
            BUSY: begin
                work_nx   = step_data;
                sticky_nx = step_sticky;
                count_nx  = count - SW'(1);
                if (count == SW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (down_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Negative results that lost set bits are floored; bump them back toward zero.
        load_result = (state_nx == DONE) && (state != DONE);
        result_nx   = work_nx + N'((mode_nx == MODE_DIV) & work_nx[N-1] & sticky_nx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= MODE_ASR;
            work      <= '0;
            count     <= '0;
            sticky    <= 1'b0;
            down_data <= '0;
        end else begin
            state  <= state_nx;
            mode   <= mode_nx;
            work   <= work_nx;
            count  <= count_nx;
            sticky <= sticky_nx;
            if (load_result) begin
                down_data <= result_nx;
            end
        end
    end

    assign up_ready   = (state == IDLE);
    assign down_valid = (state == DONE);
    assign busy       = (state == BUSY) || (state == DONE);

endmodule

// File: tb/tb_seq_signed_pow2_divider.sv
// Directed and randomized checks of seq_signed_pow2_divider against an integer-arithmetic model.
module tb_seq_signed_pow2_divider;

    localparam int N  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  up_data;
    logic [SW-1:0] up_shift;
    logic          up_mode;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  down_data;
    logic          busy;

    int passed = 0;
    int total  = 0;

    seq_signed_pow2_divider #(.N(N), .SW(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .up_shift   (up_shift),
        .up_mode    (up_mode),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int clamp(input int s);
        return (s > N) ? N : s;
    endfunction

    // Floor (>>>) or truncating (/) signed division by 2^S using plain integers.
    function automatic logic [N-1:0] model(input logic [N-1:0] d, input int s, input logic m);
        int a;
        int sc;
        int r;
        a  = int'($signed(d));
        sc = clamp(s);
        if (m) r = a / (1 << sc);
        else   r = a >>> sc;
        return N'(r);
    endfunction

    // Offer one operand, wait for the result, check value and latency, then consume it.
    task automatic run_op(input logic [N-1:0] d, input int s, input logic m, input string tag);
        int lat;
        @(negedge clk);
        check({tag, " up_ready"}, 32'(up_ready), 32'd1);
        up_valid   = 1'b1;
        up_data    = d;
        up_shift   = SW'(s);
        up_mode    = m;
        down_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        up_valid = 1'b0;
        lat = 1;
        while (!down_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " data"}, 32'(down_data), 32'(model(d, s, m)));
        check({tag, " latency"}, 32'(lat), 32'(clamp(s) + 1));
        @(posedge clk);
    endtask

    initial begin
        logic [N-1:0] held;
        rst        = 1'b1;
        up_valid   = 1'b0;
        up_data    = '0;
        up_shift   = '0;
        up_mode    = 1'b0;
        down_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset up_ready", 32'(up_ready), 32'd1);
        check("reset down_valid", 32'(down_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset down_data", 32'(down_data), 32'd0);
        rst = 1'b0;

        run_op(8'hE5, 2, 1'b0, "e5 s2 asr");
        run_op(8'hE5, 2, 1'b1, "e5 s2 div");
        run_op(8'hF8, 2, 1'b0, "f8 s2 asr");
        run_op(8'hF8, 2, 1'b1, "f8 s2 div");
        run_op(8'h64, 3, 1'b0, "64 s3 asr");
        run_op(8'h64, 3, 1'b1, "64 s3 div");
        run_op(8'h80, 0, 1'b0, "80 s0 asr");
        run_op(8'h80, 0, 1'b1, "80 s0 div");
        run_op(8'h80, 8, 1'b0, "80 s8 asr");
        run_op(8'h80, 8, 1'b1, "80 s8 div");
        run_op(8'h80, 15, 1'b0, "80 s15 asr");
        run_op(8'h80, 15, 1'b1, "80 s15 div");
        run_op(8'h7F, 8, 1'b0, "7f s8 asr");
        run_op(8'h7F, 15, 1'b1, "7f s15 div");
        check("literal e5 s2 asr", 32'(model(8'hE5, 2, 1'b0)), 32'h0F9);

        // busy stays high across BUSY and DONE for an S=3 operation
        @(negedge clk);
        up_valid = 1'b1; up_data = 8'h64; up_shift = SW'(3); up_mode = 1'b0; down_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        up_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("s3 busy in BUSY", 32'({busy, down_valid}), 32'b10);
            @(negedge clk);
        end
        check("s3 busy in DONE", 32'({busy, down_valid}), 32'b11);
        check("s3 data", 32'(down_data), 32'h0C);

        // backpressure: DONE holds for 5 cycles, up_valid pulses ignored
        held = down_data;
        for (int i = 0; i < 5; i++) begin
            up_valid = i[0];
            up_data  = 8'h11;
            up_shift = SW'(1);
            check("bp down_valid", 32'(down_valid), 32'd1);
            check("bp down_data", 32'(down_data), 32'(held));
            check("bp up_ready", 32'(up_ready), 32'd0);
            @(negedge clk);
        end
        up_valid   = 1'b0;
        down_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp release up_ready", 32'(up_ready), 32'd1);
        check("bp release down_valid", 32'(down_valid), 32'd0);

        // reset during the second BUSY cycle of an S=5 operation
        up_valid = 1'b1; up_data = 8'h9C; up_shift = SW'(5); up_mode = 1'b1;
        @(posedge clk);
        @(negedge clk);
        up_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst up_ready", 32'(up_ready), 32'd1);
        check("midrst down_valid", 32'(down_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst down_data", 32'(down_data), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("midrst no result", 32'(down_valid), 32'd0);
        end
        run_op(8'h9C, 5, 1'b1, "post reset");

        for (int i = 0; i < 3000; i++) begin
            run_op(N'($urandom), int'($urandom_range(0, 15)), 1'($urandom), "random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
